// File: rtl/b16_pkg.sv
// b16_pkg: shared lane/precision sizing and sequencer state encoding.
package b16_pkg;
  localparam int LANES = 16;
  localparam int MAXP = 16;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/b16_loom_seq_if.sv
// b16_loom_seq_if: job handshake plus bit-plane beat stream of the loom sequencer.
interface b16_loom_seq_if #(
  parameter int LANES = b16_pkg::LANES,
  parameter int MAXP = b16_pkg::MAXP
);
  localparam int CW = $clog2(MAXP);
  logic in_valid, in_ready;
  logic [LANES*MAXP-1:0] in_act, in_wgt;
  logic [CW-1:0] in_pa, in_pw;
  logic pl_valid;
  logic [LANES-1:0] pl_act, pl_wgt;
  logic pl_first, grp_last, grp_sel, grp_sign, done;
  modport master (
    output in_valid, in_act, in_wgt, in_pa, in_pw,
    input in_ready, pl_valid, pl_act, pl_wgt, pl_first, grp_last, grp_sel, grp_sign, done
  );
  modport slave (
    input in_valid, in_act, in_wgt, in_pa, in_pw,
    output in_ready, pl_valid, pl_act, pl_wgt, pl_first, grp_last, grp_sel, grp_sign, done
  );
endinterface

// File: rtl/b16_plane_mux.sv
// b16_plane_mux: picks bit k from each of LANES packed MAXP-bit words.
module b16_plane_mux #(
  parameter int LANES = 16,
  parameter int MAXP = 16
) (
  input logic [LANES*MAXP-1:0] words_i,
  input logic [$clog2(MAXP)-1:0] k_i,
  output logic [LANES-1:0] bits_o
);
  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [MAXP-1:0] w;
    assign w = words_i[n*MAXP +: MAXP];
    assign bits_o[n] = w[k_i];
  end
endmodule

// File: rtl/b16_loom_seq.sv
// b16_loom_seq: serialises captured activation/weight words into MSB-first bit-plane pairs,
// weight plane outer, activation plane inner, one beat per cycle.
module b16_loom_seq #(
  parameter int LANES = b16_pkg::LANES,
  parameter int MAXP = b16_pkg::MAXP
) (
  input logic clk,
  input logic rst_n,
  b16_loom_seq_if.slave bus
);
  localparam int CW = $clog2(MAXP);
  b16_pkg::state_e state_q, state_d;
  logic [LANES*MAXP-1:0] act_q, act_d, wgt_q, wgt_d;
  logic [CW-1:0] pa_q, pa_d, pw_q, pw_d, i_q, i_d, j_q, j_d;
  logic [LANES-1:0] act_bits, wgt_bits;
  logic run, last, accept;
  assign run = state_q == b16_pkg::RUN;
  assign last = run && i_q == '0 && j_q == '0;
  assign bus.in_ready = rst_n && (!run || last);
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    state_d = state_q;
    act_d = act_q;
    wgt_d = wgt_q;
    pa_d = pa_q;
    pw_d = pw_q;
    i_d = i_q;
    j_d = j_q;
    if (accept) begin
      state_d = b16_pkg::RUN;
      act_d = bus.in_act;
      wgt_d = bus.in_wgt;
      pa_d = bus.in_pa;
      pw_d = bus.in_pw;
      i_d = bus.in_pa;
      j_d = bus.in_pw;
    end else if (last) begin
      state_d = b16_pkg::IDLE;
    end else if (run) begin
      i_d = i_q == '0 ? pa_q : i_q - CW'(1);
      j_d = i_q == '0 ? j_q - CW'(1) : j_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= b16_pkg::IDLE;
      act_q <= '0;
      wgt_q <= '0;
      pa_q <= '0;
      pw_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      state_q <= state_d;
      act_q <= act_d;
      wgt_q <= wgt_d;
      pa_q <= pa_d;
      pw_q <= pw_d;
      i_q <= i_d;
      j_q <= j_d;
    end
  end
  b16_plane_mux #(.LANES(LANES), .MAXP(MAXP)) u_act (.words_i(act_q), .k_i(i_q), .bits_o(act_bits));
  b16_plane_mux #(.LANES(LANES), .MAXP(MAXP)) u_wgt (.words_i(wgt_q), .k_i(j_q), .bits_o(wgt_bits));
  // i and j never exceed pa-1 / pw-1, so operand bits above precision are never selected
  assign bus.pl_valid = run;
  assign bus.pl_act = run ? act_bits : '0;
  assign bus.pl_wgt = run ? wgt_bits : '0;
  assign bus.pl_first = run && i_q == pa_q;
  assign bus.grp_last = run && i_q == '0;
  assign bus.grp_sel = bus.grp_last && j_q == pw_q;
  assign bus.grp_sign = bus.grp_sel && pw_q != '0;
  assign bus.done = last;
endmodule

// File: tb/tb_b16_loom_seq.sv
// tb_b16_loom_seq: table-driven beat vectors, back-to-back/reset/garbage sequences and a
// random end-to-end popcount/accumulate check against the signed dot product.
module tb_b16_loom_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  b16_loom_seq_if bus();
  b16_loom_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic start;
    logic [3:0] pa_m1, pw_m1;
    logic [255:0] act, wgt;
    logic [63:0] exp;
  } vec_t;
  vec_t v[10];
  function automatic vec_t mk(input logic s, input logic [3:0] pa, input logic [3:0] pw,
                              input logic [255:0] a, input logic [255:0] w, input logic r,
                              input logic vl, input logic [15:0] xa, input logic [15:0] xw,
                              input logic [4:0] f);
    vec_t x;
    x.start = s;
    x.pa_m1 = pa;
    x.pw_m1 = pw;
    x.act = a;
    x.wgt = w;
    x.exp = {25'd0, r, vl, xa, xw, f};
    return x;
  endfunction
  function automatic logic [63:0] outs();
    return {25'd0, bus.in_ready, bus.pl_valid, bus.pl_act, bus.pl_wgt,
            bus.pl_first, bus.grp_last, bus.grp_sel, bus.grp_sign, bus.done};
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic start(input logic [3:0] pa_m1, input logic [3:0] pw_m1,
                       input logic [255:0] a, input logic [255:0] w);
    int k = 0;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("start_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_pa = pa_m1;
    bus.in_pw = pw_m1;
    bus.in_act = a;
    bus.in_wgt = w;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [255:0] ba, bw;
    int nv, nd;
    bus.in_valid = 1'b0;
    bus.in_act = '0;
    bus.in_wgt = '0;
    bus.in_pa = '0;
    bus.in_pw = '0;
    ba = 256'h0006_000A;
    bw = 256'h0001_0002;
    v[0] = mk(1, 0, 0, {16{16'h0001}}, 256'h1, 1, 1, 16'hFFFF, 16'h0001, 5'b11101);
    v[1] = mk(1, 3, 1, ba, bw, 0, 1, 16'h0001, 16'h0001, 5'b10000);
    v[2] = mk(0, 0, 0, '0, '0, 0, 1, 16'h0002, 16'h0001, 5'b00000);
    v[3] = mk(0, 0, 0, '0, '0, 0, 1, 16'h0003, 16'h0001, 5'b00000);
    v[4] = mk(0, 0, 0, '0, '0, 0, 1, 16'h0000, 16'h0001, 5'b01110);
    v[5] = mk(0, 0, 0, '0, '0, 0, 1, 16'h0001, 16'h0002, 5'b10000);
    v[6] = mk(0, 0, 0, '0, '0, 0, 1, 16'h0002, 16'h0002, 5'b00000);
    v[7] = mk(0, 0, 0, '0, '0, 0, 1, 16'h0003, 16'h0002, 5'b00000);
    v[8] = mk(0, 0, 0, '0, '0, 1, 1, 16'h0000, 16'h0002, 5'b01001);
    v[9] = mk(0, 0, 0, '0, '0, 1, 0, 16'h0000, 16'h0000, 5'b00000);
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    rst_n = 1'b1;
    #1 chk("post_reset_ready", outs(), {25'd0, 1'b1, 38'd0});
    @(negedge clk);
    for (int r = 0; r < 10; r++) begin
      if (v[r].start) start(v[r].pa_m1, v[r].pw_m1, v[r].act, v[r].wgt);
      chk($sformatf("vec%0d", r), outs(), v[r].exp);
      @(negedge clk);
    end
    // back-to-back: pa=2,pw=2 then pa=3,pw=1 accepted on the final beat
    start(4'd1, 4'd1, 256'h0, {16{16'h0001}});
    nv = 0;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      nv += int'(bus.pl_valid);
      nd += int'(bus.done);
      if (c == 3) begin
        chk("b2b_ready_last", 64'(bus.in_ready), 64'd1);
        chk("b2b_done1", 64'(bus.done), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_pa = 4'd2;
        bus.in_pw = 4'd0;
        bus.in_act = {16{16'h0004}};
        bus.in_wgt = 256'h0001_0000;
      end
      if (c == 4) begin
        bus.in_valid = 1'b0;
        chk("b2b_second_first", outs(), {25'd0, 1'b0, 1'b1, 16'hFFFF, 16'h0002, 5'b10000});
      end
      @(negedge clk);
    end
    chk("b2b_valid_count", 64'(nv), 64'd7);
    chk("b2b_done_count", 64'(nd), 64'd2);
    start(4'd2, 4'd0, {16{16'hFFF8}}, {16{16'hFFFF}});
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("garbage_act%0d", b), {46'd0, bus.pl_valid, bus.pl_act, 1'b0}, {46'd0, 1'b1, 16'h0000, 1'b0});
      @(negedge clk);
    end
    start(4'd3, 4'd3, {16{16'hA5C3}}, {16{16'h3C5A}});
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midjob_reset_outs", outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midjob_release_ready", outs(), {25'd0, 1'b1, 38'd0});
    nv = 0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nv += int'(bus.pl_valid);
      nd += int'(bus.done);
    end
    chk("midjob_no_done", 64'(nd), 64'd0);
    chk("midjob_no_valid", 64'(nv), 64'd0);
    for (int t = 0; t < 20; t++) begin
      int pa, pw, beats, cyc;
      logic fin;
      logic [255:0] a, w;
      longint acc, res, expd, av, wv;
      pa = int'($urandom_range(1, 16));
      pw = int'($urandom_range(1, 16));
      for (int n = 0; n < 16; n++) begin
        a[n*16 +: 16] = 16'($urandom);
        w[n*16 +: 16] = 16'($urandom);
      end
      expd = 0;
      for (int n = 0; n < 16; n++) begin
        av = longint'(a[n*16 +: 16]) & ((longint'(1) << pa) - 1);
        wv = longint'(w[n*16 +: 16]) & ((longint'(1) << pw) - 1);
        if (pw > 1 && ((wv >> (pw - 1)) & 1) == 1) wv -= longint'(1) << pw;
        expd += av * wv;
      end
      start(4'(pa - 1), 4'(pw - 1), a, w);
      beats = 0;
      cyc = 0;
      acc = 0;
      res = 0;
      fin = 1'b0;
      while (!fin && cyc < 300) begin
        if (bus.pl_valid) begin
          beats++;
          acc = bus.pl_first ? longint'($countones(bus.pl_act & bus.pl_wgt))
                             : acc * 2 + longint'($countones(bus.pl_act & bus.pl_wgt));
          if (bus.grp_last) res = bus.grp_sel ? (bus.grp_sign ? -acc : acc) : res * 2 + acc;
        end
        fin = bus.done;
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("e2e%0d_done pa=%0d pw=%0d", t, pa, pw), 64'(fin), 64'd1);
      chk($sformatf("e2e%0d_beats", t), 64'(beats), 64'(pa * pw));
      chk($sformatf("e2e%0d_dot", t), 64'(res), 64'(expd));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/b16_loom_seq.md
B16_LOOM_SEQ -- requirements
Module: b16_loom_seq

Interface
REQ-001 SHALL have parameter LANES, default 16, number of bit-serial lanes.
REQ-002 SHALL have parameter MAXP, default 16, maximum operand precision in bits.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  a job is offered.
REQ-006 SHALL have port in_ready  output  1  a job is accepted when in_valid and in_ready are both 1.
REQ-007 SHALL have port in_act  input  LANES*MAXP  activations, unsigned; lane n occupies bits [n*MAXP +: MAXP].
REQ-008 SHALL have port in_wgt  input  LANES*MAXP  weights, two's complement at precision pw, same lane packing.
REQ-009 SHALL have port in_pa  input  4  activation precision minus 1 (pa = in_pa+1).
REQ-010 SHALL have port in_pw  input  4  weight precision minus 1 (pw = in_pw+1).
REQ-011 SHALL have port pl_valid  output  1  plane pair valid this cycle.
REQ-012 SHALL have port pl_act  output  LANES  activation bit-plane, bit n from lane n.
REQ-013 SHALL have port pl_wgt  output  LANES  weight bit-plane, bit n from lane n.
REQ-014 SHALL have port pl_first  output  1  first activation plane of a weight group; downstream clears its popcount accumulator.
REQ-015 SHALL have port grp_last  output  1  last activation plane of a weight group; downstream group result is complete after this beat.
REQ-016 SHALL have port grp_sel  output  1  valid with grp_last; 1 = first weight group (add bias), 0 = shift-accumulate.
REQ-017 SHALL have port grp_sign  output  1  valid with grp_last; 1 = weight MSB group (negate).
REQ-018 SHALL have port done  output  1  one-cycle pulse on the final plane beat of a job.

Function
REQ-019 SHALL capture in_act, in_wgt, pa and pw into internal registers on acceptance; later input changes SHALL NOT affect the job in flight.
REQ-020 SHALL implement states IDLE and RUN: IDLE->RUN on acceptance; RUN->IDLE after the final beat if no new job is accepted; RUN->RUN on back-to-back acceptance.
REQ-021 SHALL drive in_ready=1 in IDLE and in the final beat of RUN; otherwise 0.
REQ-022 SHALL emit exactly pa*pw beats per job on consecutive cycles, first beat the cycle after acceptance; there is no downstream backpressure.
REQ-023 SHALL order beats with outer index j = pw-1 down to 0 (weight plane) and inner index i = pa-1 down to 0 (activation plane), i.e. MSB-first on both.
REQ-024 SHALL drive pl_act[n] = act[n][i] and pl_wgt[n] = wgt[n][j] for the current (i,j).
REQ-025 SHALL assert pl_first when i = pa-1, grp_last when i = 0, grp_sel when j = pw-1, and grp_sign when j = pw-1 and pw > 1.
REQ-026 SHALL assert grp_sel and grp_sign only on beats where grp_last=1, and done only on the beat with i=0 and j=0.
REQ-027 SHALL, when pa=1, assert pl_first and grp_last together on every beat; when pa=pw=1, emit one beat with pl_first, grp_last, grp_sel and done all set.
REQ-028 SHALL ignore operand bits at positions >= pa (activations) or >= pw (weights).
REQ-029 SHALL drive pl_valid=0 and all plane and flag outputs to 0 when no beat is active.
REQ-030 SHALL, on back-to-back acceptance, begin the new job with no idle cycle, using the newly captured operands.

Reset
REQ-031 SHALL, on rst_n low, immediately force state IDLE, clear counters and operand registers, and drive in_ready=0 and all other outputs to 0 while reset is held.
REQ-032 SHALL drive in_ready=1 in the first cycle after rst_n deasserts; a job in flight at reset SHALL be abandoned without a done pulse.

Structure
REQ-033 SHALL place LANES, MAXP and the IDLE/RUN state encoding in shared package b16_pkg.
REQ-034 SHALL use one sub-module, b16_plane_mux, which selects bit k from each of LANES packed words and is instantiated once for activations and once for weights.

Verification
REQ-035 SHALL test pa=pw=1 with act lanes all 1 and wgt lane0 only =1: one beat with pl_act=16'hFFFF, pl_wgt=16'h0001, pl_first=grp_last=grp_sel=done=1 and grp_sign=0.
REQ-036 SHALL test pa=4, pw=2 with act lane0=4'b1010 and wgt lane0=2'b10: 8 beats; beats 0-3 have pl_act[0]=1,0,1,0 and pl_wgt[0]=1; grp_last with grp_sel=grp_sign=1 on beat 3; done on beat 7.
REQ-037 SHALL test two back-to-back jobs (pa=2,pw=2 then pa=3,pw=1): in_ready high on beat 3, the second job's first beat in the next cycle, 7 contiguous pl_valid cycles in total.
REQ-038 SHALL test rst_n low at beat 5 of a pa=pw=4 job: outputs 0 in that cycle, no done pulse, in_ready=1 after release.
REQ-039 SHALL test garbage above precision, with pa=3 and act lane0=16'hFFF8: all pl_act[0] beats are 0.
REQ-040 SHALL include an end-to-end check that chains this block with the popcount and accumulator stages and compares against the signed dot product, for random pa and pw in 1..16.
